rtc_bus_responder: RTL
======================

RTC_BUS_RESPONDER -- requirements
Module: rtc_bus_responder

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100000000, giving the number of CLK cycles per RTC second.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on the CSO, ADO, WRO and RDO inputs.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; every flop is on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port CSO, input, 1 bit: chip select from the bus initiator, active-low.
REQ-006 SHALL have port ADO, input, 1 bit: phase select; 0 is the address phase, 1 is the data phase.
REQ-007 SHALL have port WRO, input, 1 bit: write strobe, active-low.
REQ-008 SHALL have port RDO, input, 1 bit: read strobe, active-low.
REQ-009 SHALL have port Bus_Dato_Dir, inout, 8 bits: the multiplexed address/data bus.
REQ-010 SHALL have port timer_done, output, 1 bit: level, high when the countdown timer has expired.
REQ-011 SHALL have port bus_drive, output, 1 bit: high while this block drives Bus_Dato_Dir.

Function
REQ-012 SHALL pass CSO, ADO, WRO and RDO through SYNC_STAGES flops each; all decode SHALL use the synchronized versions only.
REQ-013 SHALL hold an 8-bit address register. On a synchronized WRO rising edge with CSO=0 and ADO=0, the address register SHALL load Bus_Dato_Dir as sampled at that edge.
REQ-014 On a synchronized WRO rising edge with CSO=0 and ADO=1, the register at the current address SHALL load the sampled bus value.
REQ-015 Register map (all values BCD):
  - 0x21 seconds
  - 0x22 minutes
  - 0x23 hours (24 h)
  - 0x24 day
  - 0x25 month
  - 0x26 year
  - 0x41 timer seconds
  - 0x42 timer minutes
  - 0x43 timer hours
  - 0xF0 status: bit0 = timer_done; write any value to clear timer_done
REQ-016 Addresses outside the map SHALL read 0x00; writes to them SHALL be ignored.
REQ-017 Read drive rule:
  - While synchronized CSO=0, ADO=1 and RDO=0, Bus_Dato_Dir SHALL carry the registered read data of the current address and bus_drive SHALL be 1.
  - The bus SHALL drive no later than SYNC_STAGES+1 cycles after RDO falls.
  - The bus SHALL return to high-Z no later than SYNC_STAGES+1 cycles after RDO rises or CSO rises.
  - In all other states the bus SHALL be high-Z.
REQ-018 The block SHALL never drive the bus while synchronized WRO=0; if RDO and WRO are low together, write wins and the bus stays high-Z.
REQ-019 Read data SHALL be captured on the cycle the drive window opens and held stable for the whole window.
REQ-020 A 27-bit prescaler SHALL count 0..TICKS_PER_SEC-1, wrap to 0, and issue a one-cycle tick on wrap.
REQ-021 Calendar advance on each tick:
  - Seconds 59 -> 00 carries to minutes.
  - Minutes 59 -> 00 carries to hours.
  - Hours 23 -> 00 carries to day.
  - Day rolls over past the month length -> 01 and carries to month. Month lengths are 31/30, and February has 29 days when the binary value of year mod 4 = 0, otherwise 28.
  - Month 12 -> 01 carries to year.
  - Year 99 -> 00.
REQ-022 Timer on each tick, when the timer value is nonzero:
  - Decrement in BCD with borrow: seconds 00 -> 59 borrows from minutes; minutes 00 -> 59 borrows from hours.
  - The transition to 00:00:00 SHALL set timer_done on the following cycle.
  - A timer at 00:00:00 SHALL not count.
REQ-023 A bus write to any timer register SHALL clear timer_done in the same cycle.
REQ-024 If a bus write and a tick hit the same register group (time or timer) in one cycle:
  - The written register takes the bus value.
  - The tick's effect on that register is discarded.
  - Carries out of the written register are suppressed.
  - Other registers in the group advance normally.
REQ-025 Written values SHALL be stored as given, with no BCD validation. Increment logic applied to an illegal BCD digit SHALL produce the wrap value of that field.

Reset
REQ-026 While Reset=0, and independent of CLK:
  - Time and timer registers SHALL hold 00, except day=01 and month=01.
  - Address register = 0x00, prescaler = 0, synchronizers = 1.
  - timer_done = 0, bus_drive = 0, Bus_Dato_Dir high-Z.
REQ-027 Reset asserted during a bus cycle SHALL abort it; the bus SHALL be released immediately and no write SHALL commit.

Verification
REQ-028 Address 0x23 + data write 0x17, then address 0x23 + read -> the bus reads 0x17 within SYNC_STAGES+1 cycles of RDO low, with bus_drive=1.
REQ-029 Time set to 23:59:59, 31/12/99, TICKS_PER_SEC=4, run 4 cycles -> 00:00:00, 01/01/00.
REQ-030 Date set to 28/02, year 0x24, run 1 day of ticks -> 29/02; with year 0x23 -> 01/03.
REQ-031 Timer set to 00:01:00, run 60 ticks -> 00:00:00 and timer_done=1; write to 0xF0 -> timer_done=0; status read 0x00.
REQ-032 Seconds write 0x30 coincident with a tick while seconds=0x59 -> seconds=0x30 and minutes unchanged.
REQ-033 Reset pulled low mid-read -> the bus goes high-Z immediately, all registers reach their REQ-026 values, and the address and data written before reset read back as reset values.

Source files
------------

// File: rtl/rtc_bus_responder.sv
// Real-time clock with a multiplexed 8-bit address/data bus responder.
//
// Ports:
//   CLK          - single clock, all flops on the rising edge
//   Reset        - asynchronous active-low reset
//   CSO          - chip select, active-low
//   ADO          - phase select: 0 address phase, 1 data phase
//   WRO          - write strobe, active-low
//   RDO          - read strobe, active-low
//   Bus_Dato_Dir - bidirectional address/data bus
//   timer_done   - high once the countdown timer has reached 00:00:00
//   bus_drive    - high while this block drives Bus_Dato_Dir
//
// Registers (BCD): 0x21..0x26 sec/min/hour/day/month/year,
// 0x41..0x43 timer sec/min/hour, 0xF0 status (bit0 = timer_done, write clears).
module rtc_bus_responder #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       CSO,
  input  logic       ADO,
  input  logic       WRO,
  input  logic       RDO,
  inout  wire  [7:0] Bus_Dato_Dir,
  output logic       timer_done,
  output logic       bus_drive
);

  localparam logic [26:0] PrescMax   = 27'(TICKS_PER_SEC - 1);
  localparam logic [7:0]  AddrSec    = 8'h21;
  localparam logic [7:0]  AddrMin    = 8'h22;
  localparam logic [7:0]  AddrHour   = 8'h23;
  localparam logic [7:0]  AddrDay    = 8'h24;
  localparam logic [7:0]  AddrMon    = 8'h25;
  localparam logic [7:0]  AddrYear   = 8'h26;
  localparam logic [7:0]  AddrTSec   = 8'h41;
  localparam logic [7:0]  AddrTMin   = 8'h42;
  localparam logic [7:0]  AddrTHour  = 8'h43;
  localparam logic [7:0]  AddrStatus = 8'hF0;

  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9);
  endfunction

  // Returns {carry, next}. Illegal digits jump to the wrap value without a carry.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] max,
                                         input logic [7:0] wrap);
    logic [8:0] r;
    if (!bcd_valid(v))         r = {1'b0, wrap};
    else if (v >= max)         r = {1'b1, wrap};
    else if (v[3:0] == 4'd9)   r = {1'b0, v[7:4] + 4'd1, 4'd0};
    else                       r = {1'b0, v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  // Returns {borrow, next}. Illegal or out-of-range values jump to top without a borrow.
  function automatic logic [8:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
    logic [8:0] r;
    if (!bcd_valid(v) || (v > top)) r = {1'b0, top};
    else if (v == 8'h00)            r = {1'b1, top};
    else if (v[3:0] == 4'd0)        r = {1'b0, v[7:4] - 4'd1, 4'd9};
    else                            r = {1'b0, v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  // Synchronizer bit order: {CSO, ADO, WRO, RDO}
  logic [3:0]  sync_q [SYNC_STAGES];
  logic        wr_prev_q;
  logic [7:0]  addr_q;
  logic [26:0] presc_q, presc_d;
  logic [7:0]  sec_q, min_q, hour_q, day_q, mon_q, year_q;
  logic [7:0]  sec_d, min_d, hour_d, day_d, mon_d, year_d;
  logic [7:0]  tsec_q, tmin_q, thour_q;
  logic [7:0]  tsec_d, tmin_d, thour_d;
  logic        timer_done_q, timer_done_d;
  logic        drive_q;
  logic [7:0]  rdata_q, rdata_d;

  logic       cs_s, ad_s, wr_s, rd_s;
  logic       wr_rise, addr_we, data_we, rd_win, drive_on, tick;
  logic [7:0] bus_in, rd_mux, mlen;
  logic       we_sec, we_min, we_hour, we_day, we_mon, we_year;
  logic       we_tsec, we_tmin, we_thour, we_status, t_we;
  logic [8:0] sec_inc, min_inc, hour_inc, day_inc, mon_inc;
  logic [7:0] year_inc;
  logic       c_min, c_hour, c_day, c_mon, c_year;
  logic [8:0] tsec_dec, tmin_dec;
  logic [7:0] thour_dec;
  logic       timer_nz, tdec, b_min, b_hour, expire;

  assign cs_s   = sync_q[SYNC_STAGES-1][3];
  assign ad_s   = sync_q[SYNC_STAGES-1][2];
  assign wr_s   = sync_q[SYNC_STAGES-1][1];
  assign rd_s   = sync_q[SYNC_STAGES-1][0];
  assign bus_in = Bus_Dato_Dir;

  assign wr_rise = wr_s & ~wr_prev_q;
  assign addr_we = wr_rise & ~cs_s & ~ad_s;
  assign data_we = wr_rise & ~cs_s & ad_s;
  // A low write strobe always closes the read window: write wins.
  assign rd_win  = ~cs_s & ad_s & ~rd_s & wr_s;
  assign tick    = (presc_q == PrescMax);
  assign presc_d = tick ? 27'd0 : presc_q + 27'd1;

  assign we_sec    = data_we & (addr_q == AddrSec);
  assign we_min    = data_we & (addr_q == AddrMin);
  assign we_hour   = data_we & (addr_q == AddrHour);
  assign we_day    = data_we & (addr_q == AddrDay);
  assign we_mon    = data_we & (addr_q == AddrMon);
  assign we_year   = data_we & (addr_q == AddrYear);
  assign we_tsec   = data_we & (addr_q == AddrTSec);
  assign we_tmin   = data_we & (addr_q == AddrTMin);
  assign we_thour  = data_we & (addr_q == AddrTHour);
  assign we_status = data_we & (addr_q == AddrStatus);
  assign t_we      = we_tsec | we_tmin | we_thour;

  // Month length; leap test uses the binary value of the year register.
  always_comb begin
    mlen = 8'h31;
    case (mon_q)
      8'h04, 8'h06, 8'h09, 8'h11: mlen = 8'h30;
      8'h02:   mlen = (year_q[1:0] == 2'b00) ? 8'h29 : 8'h28;
      default: mlen = 8'h31;
    endcase
  end

  // Calendar: a written register takes the bus value and blocks its own carry-out.
  always_comb begin
    sec_inc  = bcd_inc(sec_q, 8'h59, 8'h00);
    min_inc  = bcd_inc(min_q, 8'h59, 8'h00);
    hour_inc = bcd_inc(hour_q, 8'h23, 8'h00);
    day_inc  = bcd_inc(day_q, mlen, 8'h01);
    mon_inc  = bcd_inc(mon_q, 8'h12, 8'h01);
    year_inc = 8'(bcd_inc(year_q, 8'h99, 8'h00));

    c_min  = tick & sec_inc[8] & ~we_sec;
    c_hour = c_min & min_inc[8] & ~we_min;
    c_day  = c_hour & hour_inc[8] & ~we_hour;
    c_mon  = c_day & day_inc[8] & ~we_day;
    c_year = c_mon & mon_inc[8] & ~we_mon;

    sec_d  = we_sec  ? bus_in : (tick   ? sec_inc[7:0]  : sec_q);
    min_d  = we_min  ? bus_in : (c_min  ? min_inc[7:0]  : min_q);
    hour_d = we_hour ? bus_in : (c_hour ? hour_inc[7:0] : hour_q);
    day_d  = we_day  ? bus_in : (c_day  ? day_inc[7:0]  : day_q);
    mon_d  = we_mon  ? bus_in : (c_mon  ? mon_inc[7:0]  : mon_q);
    year_d = we_year ? bus_in : (c_year ? year_inc      : year_q);
  end

  // Countdown timer, frozen at 00:00:00.
  always_comb begin
    timer_nz  = |{tsec_q, tmin_q, thour_q};
    tdec      = tick & timer_nz;
    tsec_dec  = bcd_dec(tsec_q, 8'h59);
    tmin_dec  = bcd_dec(tmin_q, 8'h59);
    thour_dec = 8'(bcd_dec(thour_q, 8'h23));

    b_min  = tdec & tsec_dec[8] & ~we_tsec;
    b_hour = b_min & tmin_dec[8] & ~we_tmin;

    tsec_d  = we_tsec  ? bus_in : (tdec   ? tsec_dec[7:0] : tsec_q);
    tmin_d  = we_tmin  ? bus_in : (b_min  ? tmin_dec[7:0] : tmin_q);
    thour_d = we_thour ? bus_in : (b_hour ? thour_dec     : thour_q);

    expire = tdec & ~t_we & (tsec_d == 8'h00) & (tmin_d == 8'h00) & (thour_d == 8'h00);

    timer_done_d = timer_done_q;
    if (t_we || we_status) timer_done_d = 1'b0;
    if (expire)            timer_done_d = 1'b1;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (addr_q)
      AddrSec:    rd_mux = sec_q;
      AddrMin:    rd_mux = min_q;
      AddrHour:   rd_mux = hour_q;
      AddrDay:    rd_mux = day_q;
      AddrMon:    rd_mux = mon_q;
      AddrYear:   rd_mux = year_q;
      AddrTSec:   rd_mux = tsec_q;
      AddrTMin:   rd_mux = tmin_q;
      AddrTHour:  rd_mux = thour_q;
      AddrStatus: rd_mux = {7'd0, timer_done_q};
      default:    rd_mux = 8'h00;
    endcase
  end

  // Capture once as the window opens so the driven value stays stable.
  assign rdata_d = (rd_win && !drive_q) ? rd_mux : rdata_q;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'hF;
      wr_prev_q    <= 1'b1;
      addr_q       <= 8'h00;
      presc_q      <= 27'd0;
      sec_q        <= 8'h00;
      min_q        <= 8'h00;
      hour_q       <= 8'h00;
      day_q        <= 8'h01;
      mon_q        <= 8'h01;
      year_q       <= 8'h00;
      tsec_q       <= 8'h00;
      tmin_q       <= 8'h00;
      thour_q      <= 8'h00;
      timer_done_q <= 1'b0;
      drive_q      <= 1'b0;
      rdata_q      <= 8'h00;
    end else begin
      sync_q[0] <= {CSO, ADO, WRO, RDO};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      wr_prev_q    <= wr_s;
      if (addr_we) addr_q <= bus_in;
      presc_q      <= presc_d;
      sec_q        <= sec_d;
      min_q        <= min_d;
      hour_q       <= hour_d;
      day_q        <= day_d;
      mon_q        <= mon_d;
      year_q       <= year_d;
      tsec_q       <= tsec_d;
      tmin_q       <= tmin_d;
      thour_q      <= thour_d;
      timer_done_q <= timer_done_d;
      drive_q      <= rd_win;
      rdata_q      <= rdata_d;
    end
  end

  // Gating with wr_s cuts the drive the same cycle the write strobe arrives.
  assign drive_on     = drive_q & wr_s;
  assign bus_drive    = drive_on;
  assign timer_done   = timer_done_q;
  assign Bus_Dato_Dir = drive_on ? rdata_q : 8'hzz;

endmodule
